// File: rtl/kernel_mem_bank_router.sv
// Routes one Avalon-MM burst master onto NUM_BANKS memory banks with interleaved or contiguous
// address mapping, write-burst bank locking and in-order read return across banks.
module kernel_mem_bank_router #(
    parameter int unsigned NUM_BANKS        = 4,
    parameter int unsigned ADDR_W           = 33,
    parameter int unsigned DATA_W           = 512,
    parameter int unsigned BURST_W          = 5,
    parameter int unsigned INTERLEAVE_BYTES = 4096,
    parameter int unsigned MAX_PENDING      = 64
) (
    input  logic                          clock_reset_clk,
    input  logic                          clock_reset_reset,
    input  logic                          cfg_interleave,

    input  logic [ADDR_W-1:0]             s_address,
    input  logic [DATA_W/8-1:0]           s_byteenable,
    input  logic [DATA_W-1:0]             s_writedata,
    input  logic [BURST_W-1:0]            s_burstcount,
    input  logic                          s_read,
    input  logic                          s_write,
    output logic                          s_waitrequest,
    output logic [DATA_W-1:0]             s_readdata,
    output logic                          s_readdatavalid,

    output logic [NUM_BANKS*ADDR_W-1:0]   m_address,
    output logic [NUM_BANKS*DATA_W/8-1:0] m_byteenable,
    output logic [NUM_BANKS*DATA_W-1:0]   m_writedata,
    output logic [NUM_BANKS*BURST_W-1:0]  m_burstcount,
    output logic [NUM_BANKS-1:0]          m_read,
    output logic [NUM_BANKS-1:0]          m_write,
    input  logic [NUM_BANKS-1:0]          m_waitrequest,
    input  logic [NUM_BANKS-1:0]          m_readdatavalid,
    input  logic [NUM_BANKS*DATA_W-1:0]   m_readdata,

    output logic                          err_stray_rdv
);

    localparam int unsigned BankBits = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
    localparam int unsigned BankW    = (BankBits > 0) ? BankBits : 1;
    localparam int unsigned OffBits  = $clog2(INTERLEAVE_BYTES);
    localparam int unsigned PendW    = $clog2(MAX_PENDING) + 1;
    localparam int unsigned SumW     = PendW + BURST_W;

    localparam logic [ADDR_W-1:0] GranMask = ADDR_W'(INTERLEAVE_BYTES - 1);
    localparam logic [ADDR_W-1:0] TopKeep  = {ADDR_W{1'b1}} >> BankBits;

    typedef enum logic [0:0] {StIdle, StWrBurst} wr_state_e;

    wr_state_e          wr_state_q;
    logic [BankW-1:0]   wr_bank_q;
    logic [BURST_W-1:0] wr_left_q;
    logic [BankW-1:0]   rd_bank_q;
    logic [PendW-1:0]   rd_pending_q;
    logic [PendW-1:0]   rd_pending_d;
    logic               mode_q;
    logic [DATA_W-1:0]  s_readdata_q;
    logic               s_readdatavalid_q;
    logic               err_stray_q;

    logic [BankW-1:0]     cmd_bank;
    logic [ADDR_W-1:0]    cmd_local;
    logic [BankW-1:0]     tgt_bank;
    logic                 wr_busy;
    logic [SumW-1:0]      pend_sum;
    logic                 rd_stall;
    logic                 accept;
    logic                 wr_acc;
    logic                 rd_acc;
    logic [NUM_BANKS-1:0] rd_bank_oh;
    logic                 rd_beat;
    logic                 stray_rdv;

    // Address decode: bank select and bank-local address under the active mapping.
    if (NUM_BANKS == 1) begin : g_single
        assign cmd_bank  = '0;
        assign cmd_local = s_address;
    end else begin : g_multi
        always_comb begin
            cmd_bank  = '0;
            cmd_local = s_address;
            if (mode_q) begin
                cmd_bank  = BankW'(s_address >> OffBits);
                cmd_local = ((s_address >> (OffBits + BankBits)) << OffBits)
                          | (s_address & GranMask);
            end else begin
                cmd_bank  = BankW'(s_address >> (ADDR_W - BankBits));
                cmd_local = s_address & TopKeep;
            end
        end
    end

    assign wr_busy  = (wr_state_q == StWrBurst);
    // Beats after the first of a write burst stay on the locked bank.
    assign tgt_bank = wr_busy ? wr_bank_q : cmd_bank;

    assign pend_sum = SumW'(rd_pending_q) + SumW'(s_burstcount);
    assign rd_stall = s_read & ~s_write
                    & (((rd_pending_q != '0) && (cmd_bank != rd_bank_q))
                       || (pend_sum > SumW'(MAX_PENDING))
                       || wr_busy);

    assign s_waitrequest = clock_reset_reset | rd_stall | m_waitrequest[tgt_bank];
    assign accept        = (s_read | s_write) & ~s_waitrequest;
    assign wr_acc        = accept & s_write;
    assign rd_acc        = accept & s_read & ~s_write;

    always_comb begin
        m_write = '0;
        m_read  = '0;
        if (!clock_reset_reset) begin
            if (s_write) begin
                m_write = NUM_BANKS'(1) << tgt_bank;
            end else if (s_read && !rd_stall) begin
                m_read = NUM_BANKS'(1) << tgt_bank;
            end
        end
    end

    assign m_address    = {NUM_BANKS{cmd_local}};
    assign m_byteenable = {NUM_BANKS{s_byteenable}};
    assign m_writedata  = {NUM_BANKS{s_writedata}};
    assign m_burstcount = {NUM_BANKS{s_burstcount}};

    // Only beats from the bank owning the outstanding reads are forwarded.
    assign rd_bank_oh = NUM_BANKS'(1) << rd_bank_q;
    assign rd_beat    = m_readdatavalid[rd_bank_q] & (rd_pending_q != '0);
    assign stray_rdv  = (|(m_readdatavalid & ~rd_bank_oh))
                      | ((|m_readdatavalid) & (rd_pending_q == '0));

    always_comb begin
        rd_pending_d = rd_pending_q;
        if (rd_acc) begin
            rd_pending_d = rd_pending_d + PendW'(s_burstcount);
        end
        if (rd_beat) begin
            rd_pending_d = rd_pending_d - 1'b1;
        end
    end

    always_ff @(posedge clock_reset_clk) begin
        if (clock_reset_reset) begin
            wr_state_q <= StIdle;
            wr_bank_q  <= '0;
            wr_left_q  <= '0;
        end else begin
            unique case (wr_state_q)
                StIdle: begin
                    if (wr_acc) begin
                        wr_bank_q <= cmd_bank;
                        if (s_burstcount > BURST_W'(1)) begin
                            wr_left_q  <= s_burstcount - 1'b1;
                            wr_state_q <= StWrBurst;
                        end
                    end
                end
                StWrBurst: begin
                    if (wr_acc) begin
                        wr_left_q <= wr_left_q - 1'b1;
                        if (wr_left_q == BURST_W'(1)) begin
                            wr_state_q <= StIdle;
                        end
                    end
                end
                default: wr_state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clock_reset_clk) begin
        if (clock_reset_reset) begin
            rd_bank_q         <= '0;
            rd_pending_q      <= '0;
            mode_q            <= 1'b1;
            s_readdata_q      <= '0;
            s_readdatavalid_q <= 1'b0;
            err_stray_q       <= 1'b0;
        end else begin
            if (rd_acc) begin
                rd_bank_q <= cmd_bank;
            end
            rd_pending_q      <= rd_pending_d;
            s_readdata_q      <= m_readdata[rd_bank_q*DATA_W +: DATA_W];
            s_readdatavalid_q <= rd_beat;
            err_stray_q       <= err_stray_q | stray_rdv;
            // Mapping may only change while nothing is in flight.
            if (!wr_busy && (rd_pending_q == '0) && !accept) begin
                mode_q <= cfg_interleave;
            end
        end
    end

    assign s_readdata      = s_readdata_q;
    assign s_readdatavalid = s_readdatavalid_q;
    assign err_stray_rdv   = err_stray_q;

endmodule

// File: doc/kernel_mem_bank_router.md
# kernel_mem_bank_router

Parametrised router between a single kernel-side Avalon-MM burst master and NUM_BANKS global-memory bank ports. It generalises the fixed four-DDR4-bank attachment of the kernel system into N banks with run-time selectable address mapping: either bank-interleaved or contiguous. It enforces in-order read return across banks and forwards write bursts to a single locked bank. It sits between the kernel memory interconnect and the board memory controllers.

## Interface
- NUM_BANKS, 4: bank count; power of two, 1..8; BB = log2(NUM_BANKS).
- ADDR_W, 33: byte address width, same on both sides.
- DATA_W, 512: data width; byteenable width is DATA_W/8.
- BURST_W, 5: burstcount width; max burst is 2^(BURST_W-1).
- INTERLEAVE_BYTES, 4096: interleave granule; power of two; OFF = log2(INTERLEAVE_BYTES).
- MAX_PENDING, 64: max outstanding read beats; must be ≥ 2^(BURST_W-1).
- clock_reset_clk, in, 1: single clock for all logic.
- clock_reset_reset, in, 1: synchronous, active-high reset.
- cfg_interleave, in, 1: 1 = interleaved mapping, 0 = contiguous mapping.
- s_address / s_byteenable / s_writedata / s_burstcount, in, ADDR_W / DATA_W/8 / DATA_W / BURST_W: upstream command.
- s_read / s_write, in, 1: upstream request strobes.
- s_waitrequest, out, 1: upstream stall.
- s_readdata, out, DATA_W: read return data.
- s_readdatavalid, out, 1: read return valid.
- m_address / m_byteenable / m_writedata / m_burstcount, out, NUM_BANKS× each: per-bank command, flattened with bank 0 in the LSBs.
- m_read / m_write, out, NUM_BANKS: per-bank one-hot strobes.
- m_waitrequest / m_readdatavalid, in, NUM_BANKS: per-bank status.
- m_readdata, in, NUM_BANKS×DATA_W: per-bank read data.
- err_stray_rdv, out, 1: sticky flag for a protocol violation on read return.

## Operation
- **Active mode register (mode_q).**
  - Resets to 1.
  - Loads cfg_interleave only when wr_state = IDLE, rd_pending = 0, and no command is accepted that cycle.
- **Interleaved mapping (mode_q = 1).**
  - bank = addr[OFF+BB-1:OFF].
  - local = {BB'b0, addr[ADDR_W-1:OFF+BB], addr[OFF-1:0]}.
- **Contiguous mapping (mode_q = 0).**
  - bank = addr[ADDR_W-1 -: BB].
  - local = addr with those BB bits cleared.
- **NUM_BANKS = 1.** bank = 0, local = addr.
- **Command broadcast.** Address (local), byteenable, writedata and burstcount go to every bank. Only the target bank's m_read/m_write is asserted.
- **Write FSM, IDLE.**
  - An accepted write computes its bank and latches it into wr_bank.
  - If burstcount > 1, load wr_left = burstcount − 1 and go to WR_BURST.
- **Write FSM, WR_BURST.**
  - Every beat routes to wr_bank, ignoring the beat's address.
  - Each accepted beat decrements wr_left; leave for IDLE on the accept at wr_left = 1.
  - A read request is stalled in WR_BURST.
- **Bursts crossing a granule.** The whole burst goes to the first beat's bank, with no split. Upstream guarantees this never happens in interleaved mode.
- **Read tracking.** rd_bank holds the bank of the outstanding reads; rd_pending (width log2(MAX_PENDING)+1) counts outstanding read beats.
- **Read stall conditions.** A read is stalled while any of these hold:
  - rd_pending ≠ 0 and the read's bank ≠ rd_bank (this guarantees in-order return);
  - rd_pending + s_burstcount > MAX_PENDING;
  - wr_state ≠ IDLE.
- **Write stall.** Writes are never stalled for read reasons.
- **Read accept.** rd_bank ← bank and rd_pending += burstcount.
- **Read return.** Each returned beat with m_readdatavalid[rd_bank] = 1 decrements rd_pending. On a simultaneous accept and return, rd_pending = rd_pending + burstcount − 1.
- **Stray readdatavalid.** m_readdatavalid on any bank ≠ rd_bank, or any readdatavalid while rd_pending = 0:
  - sets err_stray_rdv (cleared only by reset);
  - the beat is dropped and the counter is unchanged.
- **Upstream stall.** s_waitrequest = reset | internal stall | m_waitrequest[target bank].

## Timing
- **Command path.** Combinational, zero cycle. m_* strobes follow s_* in the same cycle; s_waitrequest depends combinationally on m_waitrequest.
- **Read return.** Registered, one-cycle latency. s_readdata/s_readdatavalid at cycle t+1 reflect m_readdata[rd_bank]/m_readdatavalid[rd_bank] at cycle t.
- **Reset values.**
  - s_waitrequest = 1, s_readdatavalid = 0, s_readdata = 0.
  - m_read = m_write = 0, err_stray_rdv = 0.
  - wr_state = IDLE, rd_pending = 0, rd_bank = 0, mode_q = 1.
- **Reset mid-operation.** Outstanding reads and write bursts are discarded. Late readdatavalid beats that arrive after reset are flagged as stray.
- **Accept definition.** A command is accepted when (s_read | s_write) & !s_waitrequest.

## Test plan
- **Interleaved routing.** NUM_BANKS=4, INTERLEAVE_BYTES=4096, mode 1; write address 0x3000, burst 1 -> m_write = 4'b1000, m_address[bank3] = 0x0000. Write address 0x4010 -> bank 0, local 0x1010.
- **Contiguous routing.** ADDR_W=33, mode 0; read address 0x1_0000_0040 -> bank 2, local 0x0_0000_0040.
- **Write burst lock.** Burstcount 4 at bank 1, second-beat address pointing at bank 3 -> all 4 beats go to bank 1. Return to IDLE after the 4th accept. A read stalled during WR_BURST is accepted the cycle after.
- **Read ordering.**
  - Setup: read burst 8 to bank 0, then a read to bank 2.
  - Bank 2 stays stalled until 8 beats have returned. It is accepted in the cycle rd_pending reaches 0.
  - s_readdatavalid lags each m_readdatavalid by 1 cycle.
- **Pending limit and simultaneity.**
  - MAX_PENDING=16, rd_pending=10; burst 8 -> stalled.
  - rd_pending=8 with a beat returning that cycle, burst 8 accepted -> rd_pending = 15.
- **Stray and mode switch.**
  - m_readdatavalid[3] while rd_bank=0 -> err_stray_rdv = 1 and s_readdatavalid = 0.
  - cfg_interleave toggled while rd_pending ≠ 0 -> mode_q holds until rd_pending = 0.
